// File: rtl/fetch_seq.sv
// Y86-64 SEQ fetch stage: pulls one instruction byte-by-byte from a handshaked
// byte memory, decodes icode/ifun/rA/rB/valC, and reports valP and stat.
module fetch_seq #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] pc_in,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  input  logic        mem_err,
  output logic        busy,
  output logic        done,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [63:0]   pc_reg;
  logic [3:0]    k_reg;
  logic [3:0]    len_reg, len_next;
  logic [WW-1:0] wait_reg;

  // Working copies of the fields; published to the outputs only on DONE entry
  logic [3:0]  icode_f_reg, icode_f_next;
  logic [3:0]  ifun_f_reg, ifun_f_next;
  logic [3:0]  ra_f_reg, ra_f_next;
  logic [3:0]  rb_f_reg, rb_f_next;
  logic [63:0] valc_f_reg, valc_f_next;

  logic        ack_ok, ack_err, time_out, first, b0_ins, last, finish;
  logic        valc_hit;
  logic [2:0]  valc_idx;
  logic [2:0]  stat_next;
  logic [63:0] valp_next;

  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       len_of = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
      4'h7, 4'h8:             len_of = 4'd9;
      4'h3, 4'h4, 4'h5:       len_of = 4'd10;
      default:                len_of = 4'd1;
    endcase
  endfunction

  function automatic logic ins_of(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h6:       ins_of = (fn > 4'd3);
      4'h2, 4'h7: ins_of = (fn > 4'd6);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                  ins_of = (fn != 4'd0);
      default:    ins_of = 1'b1;
    endcase
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = REQ;
      REQ:     if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mem_req  = (state_reg == REQ);
    busy     = (state_reg == REQ) || (state_reg == DONE);
    done     = (state_reg == DONE);
    mem_addr = (state_reg == REQ) ? (pc_reg + {60'd0, k_reg}) : 64'd0;
  end

  // ---------------- byte decode ----------------
  always_comb begin
    ack_ok   = (state_reg == REQ) && mem_ack && !mem_err;
    ack_err  = (state_reg == REQ) && mem_ack && mem_err;
    time_out = (state_reg == REQ) && !mem_ack && (wait_reg == WW'(MAX_WAIT - 1));
    first    = (k_reg == 4'd0);
    b0_ins   = ack_ok && first && ins_of(mem_data[7:4], mem_data[3:0]);

    len_next     = len_reg;
    icode_f_next = icode_f_reg;
    ifun_f_next  = ifun_f_reg;
    ra_f_next    = ra_f_reg;
    rb_f_next    = rb_f_reg;
    valc_hit     = 1'b0;
    valc_idx     = 3'd0;

    if (ack_ok) begin
      if (first) begin
        icode_f_next = mem_data[7:4];
        ifun_f_next  = mem_data[3:0];
        len_next     = b0_ins ? 4'd1 : len_of(mem_data[7:4]);
      end else if ((len_reg == 4'd2 || len_reg == 4'd10) && k_reg == 4'd1) begin
        ra_f_next = mem_data[7:4];
        rb_f_next = mem_data[3:0];
      end else if (len_reg == 4'd9) begin
        valc_hit = 1'b1;
        valc_idx = 3'(k_reg - 4'd1);
      end else if (len_reg == 4'd10) begin
        valc_hit = 1'b1;
        valc_idx = 3'(k_reg - 4'd2);
      end
    end

    last   = ack_ok && (b0_ins || ((k_reg + 4'd1) == len_next));
    finish = last || ack_err || time_out;

    // Aborts take precedence; an illegal byte 0 can only arrive on a clean ack
    if (ack_err || time_out)                          stat_next = STAT_ADR;
    else if (b0_ins)                                  stat_next = STAT_INS;
    else if (icode_f_next == 4'h0 && ifun_f_next == 4'h0) stat_next = STAT_HLT;
    else                                              stat_next = STAT_AOK;

    valp_next = pc_reg + {60'd0, len_next};
  end

  // Little-endian valC assembly, one lane per byte
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_valc_lane
      assign valc_f_next[8*gi +: 8] = (valc_hit && valc_idx == 3'(gi))
                                      ? mem_data : valc_f_reg[8*gi +: 8];
    end
  endgenerate

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg      <= 64'd0;
      k_reg       <= 4'd0;
      len_reg     <= 4'd1;
      wait_reg    <= '0;
      icode_f_reg <= 4'h0;
      ifun_f_reg  <= 4'h0;
      ra_f_reg    <= 4'hF;
      rb_f_reg    <= 4'hF;
      valc_f_reg  <= 64'd0;
      icode       <= 4'h0;
      ifun        <= 4'h0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= 64'd0;
      valP        <= 64'd0;
      stat        <= STAT_AOK;
    end else if (state_reg == IDLE && start) begin
      pc_reg      <= pc_in;
      k_reg       <= 4'd0;
      len_reg     <= 4'd1;
      wait_reg    <= '0;
      icode_f_reg <= 4'h0;
      ifun_f_reg  <= 4'h0;
      ra_f_reg    <= 4'hF;
      rb_f_reg    <= 4'hF;
      valc_f_reg  <= 64'd0;
    end else if (state_reg == REQ) begin
      if (ack_ok) begin
        k_reg    <= k_reg + 4'd1;
        wait_reg <= '0;
      end else if (!mem_ack) begin
        wait_reg <= wait_reg + 1'b1;
      end
      len_reg     <= len_next;
      icode_f_reg <= icode_f_next;
      ifun_f_reg  <= ifun_f_next;
      ra_f_reg    <= ra_f_next;
      rb_f_reg    <= rb_f_next;
      valc_f_reg  <= valc_f_next;
      if (finish) begin
        icode <= icode_f_next;
        ifun  <= ifun_f_next;
        rA    <= ra_f_next;
        rB    <= rb_f_next;
        valC  <= valc_f_next;
        valP  <= valp_next;
        stat  <= stat_next;
      end
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a byte-memory responder with per-fetch wait,
// error and no-ack settings, a vector table, and multi-cycle corner sequences.
module tb_fetch_seq;

  logic        clk, rst_n, start;
  logic [63:0] pc_in;
  logic        mem_req, mem_ack, mem_err;
  logic [63:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy, done;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [2:0]  stat;

  fetch_seq #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .mem_err(mem_err), .busy(busy), .done(done),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .stat(stat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] pc;
    logic [79:0] img;   // byte i at img[8i+:8]
    int          wt;
    int          erri;
    bit          noack;
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
    logic [63:0] e_valc, e_valp;
    logic [2:0]  e_stat;
    int          e_lat;
    int          e_acks;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // responder configuration and observations
  logic [79:0] img;
  logic [63:0] cur_pc;
  int          wt, erri, acks, max_idx, waited;
  bit          noack, resp_en;
  logic        man_ack;
  logic [7:0]  man_data;

  initial begin
    mem_ack = 1'b0; mem_err = 1'b0; mem_data = 8'h00;
    waited = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        mem_ack = man_ack; mem_data = man_data; mem_err = 1'b0;
      end else if (mem_req) begin
        logic [63:0] idx;
        idx = mem_addr - cur_pc;
        if (idx > 64'd9) idx = 64'd9;
        if (int'(idx) > max_idx) max_idx = int'(idx);
        if (noack) begin
          mem_ack = 1'b0;
        end else if (waited < wt) begin
          mem_ack = 1'b0;
          waited++;
        end else begin
          mem_ack  = 1'b1;
          mem_data = img[8*int'(idx) +: 8];
          mem_err  = (int'(idx) == erri);
          waited   = 0;
          acks++;
        end
      end else begin
        mem_ack = 1'b0; mem_err = 1'b0; waited = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] pc, input logic [79:0] im, input int w,
                              input int ei, input bit na, input logic [3:0] ic,
                              input logic [3:0] fn, input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] vc, input logic [63:0] vp,
                              input logic [2:0] st, input int lat, input int ak);
    vec_t v;
    v.pc = pc; v.img = im; v.wt = w; v.erri = ei; v.noack = na;
    v.e_icode = ic; v.e_ifun = fn; v.e_ra = ra; v.e_rb = rb;
    v.e_valc = vc; v.e_valp = vp; v.e_stat = st; v.e_lat = lat; v.e_acks = ak;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    lat = 0;
    img = v.img; cur_pc = v.pc; wt = v.wt; erri = v.erri; noack = v.noack;
    acks = 0; max_idx = 0;
    @(negedge clk);
    start = 1'b1; pc_in = v.pc;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = c; break; end
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.done_timeout: got no done required done within 200 cycles", nm);
    end
    $display("fetch %s pc=%h icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d lat=%0d acks=%0d",
             nm, v.pc, icode, ifun, rA, rB, valC, valP, stat, lat, acks);
    chk({nm, ".icode"}, 64'(icode), 64'(v.e_icode));
    chk({nm, ".ifun"},  64'(ifun),  64'(v.e_ifun));
    chk({nm, ".rA"},    64'(rA),    64'(v.e_ra));
    chk({nm, ".rB"},    64'(rB),    64'(v.e_rb));
    chk({nm, ".valC"},  valC,       v.e_valc);
    chk({nm, ".valP"},  valP,       v.e_valp);
    chk({nm, ".stat"},  64'(stat),  64'(v.e_stat));
    chk({nm, ".latency"}, 64'(lat), 64'(v.e_lat));
    chk({nm, ".acks"},  64'(acks),  64'(v.e_acks));
    chk({nm, ".max_idx"}, 64'(max_idx), 64'((v.e_acks == 0) ? 0 : v.e_acks - 1));
    @(negedge clk);
    chk({nm, ".done_pulse"}, 64'(done), 64'd0);
    chk({nm, ".idle_busy"},  64'(busy), 64'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int dcnt, lat;
    resp_en = 1'b1; man_ack = 1'b0; man_data = 8'h00;
    img = '0; cur_pc = '0; wt = 0; erri = -1; noack = 1'b0; acks = 0; max_idx = 0;
    start = 1'b0; pc_in = 64'd0; rst_n = 1'b0;

    //            pc                     image                              wt err na  ic    fn    rA    rB    valC                    valP                   st  lat acks
    vecs[0]  = mk(64'h100, 80'h0123456789ABCDEF_F3_30,                    0, -1, 0, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h10A, 3'd1, 11, 10);
    vecs[1]  = mk(64'h200, 80'h00_0000000000000040_73,                    1, -1, 0, 4'h7, 4'h3, 4'hF, 4'hF, 64'h40,               64'h209, 3'd1, 19, 9);
    vecs[2]  = mk(64'h300, 80'hC0,                                        0, -1, 0, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0,                64'h301, 3'd4, 2,  1);
    vecs[3]  = mk(64'h310, 80'h65,                                        0, -1, 0, 4'h6, 4'h5, 4'hF, 4'hF, 64'h0,                64'h311, 3'd4, 2,  1);
    vecs[4]  = mk(64'h400, 80'h1122334455667788_12_40,                    0,  3, 0, 4'h4, 4'h0, 4'h1, 4'h2, 64'h88,               64'h40A, 3'd3, 5,  4);
    vecs[5]  = mk(64'h500, 80'h10,                                        0, -1, 1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                64'h501, 3'd3, 17, 0);
    vecs[6]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 80'h1220,                      0, -1, 0, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0,                64'h1,   3'd1, 3,  2);
    vecs[7]  = mk(64'h600, 80'h00,                                        0, -1, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                64'h601, 3'd2, 2,  1);
    vecs[8]  = mk(64'h700, 80'h2361,                                      2, -1, 0, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0,                64'h702, 3'd1, 7,  2);
    vecs[9]  = mk(64'h800, 80'h00_1122334455667788_80,                    0, -1, 0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h1122334455667788, 64'h809, 3'd1, 10, 9);
    vecs[10] = mk(64'h900, 80'h27,                                        0, -1, 0, 4'h2, 4'h7, 4'hF, 4'hF, 64'h0,                64'h901, 3'd4, 2,  1);
    vecs[11] = mk(64'hA00, 80'h10,                                        0, -1, 0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                64'hA01, 3'd1, 2,  1);

    repeat (3) @(negedge clk);
    chk("rst.mem_req",  64'(mem_req), 64'd0);
    chk("rst.mem_addr", mem_addr,     64'd0);
    chk("rst.busy",     64'(busy),    64'd0);
    chk("rst.done",     64'(done),    64'd0);
    chk("rst.icode",    64'(icode),   64'd0);
    chk("rst.ifun",     64'(ifun),    64'd0);
    chk("rst.rA",       64'(rA),      64'hF);
    chk("rst.rB",       64'(rB),      64'hF);
    chk("rst.valC",     valC,         64'd0);
    chk("rst.valP",     valP,         64'd0);
    chk("rst.stat",     64'(stat),    64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout with start pulses in the window, then a stray ack in IDLE
    img = 80'h10; cur_pc = 64'h500; wt = 0; erri = -1; noack = 1'b1; acks = 0; max_idx = 0;
    @(negedge clk);
    start = 1'b1; pc_in = 64'h500;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 6);
      pc_in = (c == 5 || c == 6) ? 64'h900 : 64'h500;
      if (done) begin lat = c; break; end
    end
    start = 1'b0;
    $display("fetch tmo_start pc=500 stat=%0d valP=%h lat=%0d", stat, valP, lat);
    chk("tmo.latency", 64'(lat),     64'd17);
    chk("tmo.stat",    64'(stat),    64'd3);
    chk("tmo.valP",    valP,         64'h501);
    chk("tmo.max_idx", 64'(max_idx), 64'd0);
    @(negedge clk);
    chk("tmo.idle_busy", 64'(busy), 64'd0);
    resp_en = 1'b0; man_ack = 1'b1; man_data = 8'h10;
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || mem_req || busy) dcnt++;
    end
    man_ack = 1'b0;
    @(negedge clk);
    resp_en = 1'b1;
    $display("fetch late_ack activity=%0d stat=%0d", dcnt, stat);
    chk("late_ack.activity", 64'(dcnt), 64'd0);
    chk("late_ack.stat",     64'(stat), 64'd3);

    // Reset in the middle of a call fetch, then a halt
    img = 80'h00_1122334455667788_80; cur_pc = 64'h800; noack = 1'b0; acks = 0; max_idx = 0;
    @(negedge clk);
    start = 1'b1; pc_in = 64'h800;
    repeat (4) begin @(negedge clk); start = 1'b0; end
    rst_n = 1'b0;
    @(negedge clk);
    $display("fetch rst_mid mem_req=%0d busy=%0d stat=%0d done=%0d", mem_req, busy, stat, done);
    chk("rst_mid.mem_req", 64'(mem_req), 64'd0);
    chk("rst_mid.busy",    64'(busy),    64'd0);
    chk("rst_mid.stat",    64'(stat),    64'd1);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("rst_mid.no_done", 64'(dcnt), 64'd0);
    run_vec(mk(64'h40, 80'h00, 0, -1, 0, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41, 3'd2, 2, 1), "halt_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
